// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM/WB boundary bundle for wb_stage_pipe.
//   master: drives the MEM-stage side (en, flush, in_valid, reg_write, waddr,
//           wb_sel, load_size, load_signed, alu_result, read_data_mem,
//           pc_adder, cnt_clr) and observes the writeback results.
//   slave : the writeback stage; drives rf_we, rf_waddr, rf_wdata, wb_valid,
//           misalign, retire_cnt.
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              en;
  logic              flush;
  logic              in_valid;
  logic              reg_write;
  logic [REG_AW-1:0] waddr;
  logic [1:0]        wb_sel;
  logic [1:0]        load_size;
  logic              load_signed;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] read_data_mem;
  logic [DATA_W-1:0] pc_adder;
  logic              cnt_clr;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              wb_valid;
  logic              misalign;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output en, flush, in_valid, reg_write, waddr, wb_sel, load_size,
           load_signed, alu_result, read_data_mem, pc_adder, cnt_clr,
    input  rf_we, rf_waddr, rf_wdata, wb_valid, misalign, retire_cnt
  );

  modport slave (
    input  en, flush, in_valid, reg_write, waddr, wb_sel, load_size,
           load_signed, alu_result, read_data_mem, pc_adder, cnt_clr,
    output rf_we, rf_waddr, rf_wdata, wb_valid, misalign, retire_cnt
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: registered MIPS writeback stage (MEM/WB pipeline register).
// Selects ALU result, aligned/extended load data or the link address, and
// drives the register-file write port one cycle after capture.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - wb_stage_if.slave: MEM-stage inputs, register-file write port,
//          wb_valid, misalign flag and retired-instruction counter.
// Each captured entry writes and retires only in its first WB cycle; a held
// entry (en=0) stays visible but is no longer "fresh".
module wb_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] shifted;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       ld_w;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] sel_data;
  logic              mis_d;

  logic              valid_q;
  logic              fresh_q;
  logic              we_q;
  logic [REG_AW-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mis_q;
  logic [CNT_W-1:0]  cnt_q;

  // Big-endian lanes: shifting left by the byte offset brings lane o to the
  // top of the word, so every load size reads from the same MSB position.
  assign off     = bus.alu_result[OFF_W-1:0];
  assign shifted = bus.read_data_mem << {off, 3'b000};
  assign ld_b    = shifted[DATA_W-1 -: 8];
  assign ld_h    = shifted[DATA_W-1 -: 16];
  assign ld_w    = shifted[DATA_W-1 -: 32];

  // NOTE: every signal written in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    load_val = bus.read_data_mem;
    mis_d    = 1'b0;
    case (bus.load_size)
      2'b00: load_val = bus.load_signed ? DATA_W'($signed(ld_b)) : DATA_W'(ld_b);
      2'b01: begin
        load_val = bus.load_signed ? DATA_W'($signed(ld_h)) : DATA_W'(ld_h);
        mis_d    = off[0];
      end
      2'b10: begin
        load_val = bus.load_signed ? DATA_W'($signed(ld_w)) : DATA_W'(ld_w);
        mis_d    = |off[1:0];
      end
      default: begin
        // Full-width load; at DATA_W=32 this is identical to a word load.
        load_val = bus.read_data_mem;
        mis_d    = |off;
      end
    endcase
    if (bus.wb_sel != 2'b01) mis_d = 1'b0;
  end

  always_comb begin
    sel_data = '0;
    case (bus.wb_sel)
      2'b00:   sel_data = bus.alu_result;
      2'b01:   sel_data = load_val;
      2'b10:   sel_data = bus.pc_adder;
      default: sel_data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (bus.en) begin
        valid_q <= bus.in_valid & ~bus.flush;
        fresh_q <= 1'b1;
        we_q    <= bus.reg_write;
        waddr_q <= bus.waddr;
        wdata_q <= sel_data;
        mis_q   <= bus.in_valid & ~bus.flush & mis_d;
      end else begin
        fresh_q <= 1'b0;
      end
      // Counts the entry currently in its first WB cycle; clear wins.
      if (bus.cnt_clr)
        cnt_q <= '0;
      else if (valid_q & fresh_q)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.rf_we      = valid_q & fresh_q & we_q & (waddr_q != '0) & ~mis_q;
  assign bus.rf_waddr   = waddr_q;
  assign bus.rf_wdata   = wdata_q;
  assign bus.wb_valid   = valid_q;
  assign bus.misalign   = mis_q;
  assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Testbench for wb_stage_pipe: a 32-bit instance (CNT_W=4 to exercise wrap)
// and a 64-bit instance. Expected outputs are queued when stimulus is driven
// and popped/compared one clock later.
module tb_wb_stage_pipe;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  b32 ();
  wb_stage_if #(.DATA_W(64), .REG_AW(5), .CNT_W(32)) b64 ();

  wb_stage_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  dut32 (.clk(clk), .rst(rst), .bus(b32));
  wb_stage_pipe #(.DATA_W(64), .REG_AW(5), .CNT_W(32)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  typedef struct packed {
    logic        en, flush, in_valid, reg_write;
    logic [4:0]  waddr;
    logic [1:0]  wb_sel, load_size;
    logic        load_signed;
    logic [63:0] alu, rd, pc;
    logic        cnt_clr;
  } in_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
  } obs_t;

  typedef struct {
    obs_t  e;
    bit    care;   // 0: rf_wdata is unspecified for this vector
    string name;
  } sb_t;

  sb_t  sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Small reference for the 32-bit instance's retire counter (4-bit wrap).
  logic       m_valid, m_fresh;
  logic [3:0] m_cnt;

  localparam logic [63:0] RD32 = 64'h0000_0000_80F1_7F22;
  localparam logic [63:0] RD64 = 64'h0123_4567_8000_0001;

  function automatic in_t mk(input logic en, flush, iv, rw, input logic [4:0] wa,
                             input logic [1:0] sel, sz, input logic sgn,
                             input logic [63:0] alu, rd, pc, input logic clr);
    in_t s;
    s.en = en; s.flush = flush; s.in_valid = iv; s.reg_write = rw;
    s.waddr = wa; s.wb_sel = sel; s.load_size = sz; s.load_signed = sgn;
    s.alu = alu; s.rd = rd; s.pc = pc; s.cnt_clr = clr;
    return s;
  endfunction

  function automatic obs_t ob(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                              input logic v, mis, input logic [31:0] cnt);
    obs_t o;
    o.we = we; o.waddr = wa; o.wdata = wd; o.valid = v; o.mis = mis; o.cnt = cnt;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("we=%b wa=%0d wd=%h valid=%b mis=%b cnt=%0d",
                     o.we, o.waddr, o.wdata, o.valid, o.mis, o.cnt);
  endfunction

  task automatic drive32(input in_t s);
    b32.en = s.en; b32.flush = s.flush; b32.in_valid = s.in_valid;
    b32.reg_write = s.reg_write; b32.waddr = s.waddr; b32.wb_sel = s.wb_sel;
    b32.load_size = s.load_size; b32.load_signed = s.load_signed;
    b32.alu_result = s.alu[31:0]; b32.read_data_mem = s.rd[31:0];
    b32.pc_adder = s.pc[31:0]; b32.cnt_clr = s.cnt_clr;
  endtask

  task automatic drive64(input in_t s);
    b64.en = s.en; b64.flush = s.flush; b64.in_valid = s.in_valid;
    b64.reg_write = s.reg_write; b64.waddr = s.waddr; b64.wb_sel = s.wb_sel;
    b64.load_size = s.load_size; b64.load_signed = s.load_signed;
    b64.alu_result = s.alu; b64.read_data_mem = s.rd;
    b64.pc_adder = s.pc; b64.cnt_clr = s.cnt_clr;
  endtask

  function automatic obs_t sample32();
    return ob(b32.rf_we, b32.rf_waddr, {32'h0, b32.rf_wdata}, b32.wb_valid,
              b32.misalign, {28'h0, b32.retire_cnt});
  endfunction

  function automatic obs_t sample64();
    return ob(b64.rf_we, b64.rf_waddr, b64.rf_wdata, b64.wb_valid,
              b64.misalign, b64.retire_cnt);
  endfunction

  task automatic push(input obs_t e, input bit care, input string name);
    sb_t x;
    x.e = e; x.care = care; x.name = name;
    sb.push_back(x);
  endtask

  // Drive one 32-bit vector at the falling edge, queue its expectation
  // (counter from the reference), clock it and stop 1 ns after the edge.
  task automatic apply32(input in_t s, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic v, mis,
                         input bit care, input string name);
    @(negedge clk);
    drive32(s);
    m_cnt = s.cnt_clr ? 4'd0 : m_cnt + ((m_valid & m_fresh) ? 4'd1 : 4'd0);
    m_valid = v;
    m_fresh = s.en;
    push(ob(we, wa, wd, v, mis, {28'h0, m_cnt}), care, name);
    @(posedge clk);
    #1;
  endtask

  task automatic apply64(input in_t s, input obs_t e, input string name);
    @(negedge clk);
    drive64(s);
    push(e, 1'b1, name);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    m_valid = 1'b0; m_fresh = 1'b0; m_cnt = 4'd0;
  endtask

  task automatic test_reset();
    obs_t got; sb_t x;
    rst = 1'b1;
    drive32(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    drive64(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    push(ob(0,0,0,0,0,0), 1'b1, "reset_hold");
    got = sample32(); x = sb.pop_front(); n_vec++;
    if (got !== x.e) begin n_err++; $display("FAIL %s: got %s required %s", x.name, fmt(got), fmt(x.e)); end
    @(negedge clk) rst = 1'b0;

    apply32(mk(1,0,1,1,5,2'b00,0,0,64'h1234_5678,0,0,0), 1,5,64'h1234_5678,1,0,1,"alu_r5");
    got = sample32(); x = sb.pop_front(); n_vec++;
    if (got !== x.e) begin n_err++; $display("FAIL %s: got %s required %s", x.name, fmt(got), fmt(x.e)); end
    apply32(mk(1,0,0,0,0,2'b00,0,0,0,0,0,0), 0,0,0,0,0,1,"retire_after_r5");
    got = sample32(); x = sb.pop_front(); n_vec++;
    if (got !== x.e) begin n_err++; $display("FAIL %s: got %s required %s", x.name, fmt(got), fmt(x.e)); end
    apply32(mk(1,0,1,1,6,2'b00,0,0,64'hAAAA_5555,0,0,0), 1,6,64'hAAAA_5555,1,0,1,"pre_reset_capture");
    got = sample32(); x = sb.pop_front(); n_vec++;
    if (got !== x.e) begin n_err++; $display("FAIL %s: got %s required %s", x.name, fmt(got), fmt(x.e)); end

    // Mid-stream asynchronous reset: outputs must clear before any edge.
    @(negedge clk);
    drive32(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    rst = 1'b1;
    #1;
    push(ob(0,0,0,0,0,0), 1'b1, "async_reset");
    got = sample32(); x = sb.pop_front(); n_vec++;
    if (got !== x.e) begin n_err++; $display("FAIL %s: got %s required %s", x.name, fmt(got), fmt(x.e)); end
    reset_model();
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_loads();
    obs_t got; sb_t x;
    logic [63:0] exp_d [5] = '{64'hFFFF_FF80, 64'h0000_0022, 64'h0000_7F22, 64'hFFFF_80F1, 64'h80F1_7F22};
    logic [1:0]  sz    [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    logic        sg    [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [63:0] off   [5] = '{64'd0, 64'd3, 64'd2, 64'd0, 64'd0};
    for (int i = 0; i < 5; i++) begin
      apply32(mk(1,0,1,1,7,2'b01,sz[i],sg[i],64'h1000 | off[i],RD32,0,0),
              1,7,exp_d[i],1,0,1,$sformatf("load[%0d]", i));
      got = sample32(); x = sb.pop_front(); n_vec++;
      if (got !== x.e) begin n_err++; $display("FAIL %s: got %s required %s", x.name, fmt(got), fmt(x.e)); end
    end
  endtask

  task automatic test_misalign();
    obs_t got; sb_t x;
    in_t  s  [3];
    logic we [3] = '{1'b0, 1'b0, 1'b1};
    logic mi [3] = '{1'b1, 1'b1, 1'b0};
    logic [63:0] wd [3] = '{64'h0, 64'hFFFF_F17F, 64'h0000_00F1};
    bit   care [3] = '{1'b0, 1'b1, 1'b1};
    s[0] = mk(1,0,1,1,9,2'b01,2'b10,0,64'h2002,RD32,0,0);  // lw, o=2
    s[1] = mk(1,0,1,1,9,2'b01,2'b01,1,64'h2001,RD32,0,0);  // lh, o=1
    s[2] = mk(1,0,1,1,9,2'b01,2'b00,0,64'h2001,RD32,0,0);  // lbu, o=1 (aligned)
    for (int i = 0; i < 3; i++) begin
      apply32(s[i], we[i], 9, wd[i], 1, mi[i], care[i], $sformatf("misalign[%0d]", i));
      got = sample32(); x = sb.pop_front(); n_vec++;
      if (!x.care) got.wdata = x.e.wdata;
      if (got !== x.e) begin n_err++; $display("FAIL %s: got %s required %s", x.name, fmt(got), fmt(x.e)); end
    end
  endtask

  task automatic test_link_r0_flush();
    obs_t got; sb_t x;
    in_t  s  [5];
    logic we [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic v  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0]  wa [5] = '{5'd31, 5'd0, 5'd3, 5'd4, 5'd0};
    logic [63:0] wd [5] = '{64'h0040_0008, 64'hDEAD, 64'h55, 64'h0, 64'h0};
    s[0] = mk(1,0,1,1,31,2'b10,0,0,64'hFFFF,0,64'h0040_0008,0); // jal
    s[1] = mk(1,0,1,1,0, 2'b00,0,0,64'hDEAD,0,0,0);             // write to r0
    s[2] = mk(1,1,1,1,3, 2'b00,0,0,64'h55,0,0,0);               // flushed
    s[3] = mk(1,0,1,1,4, 2'b11,0,0,64'h77,0,64'h99,0);          // reserved select
    s[4] = mk(1,0,0,0,0, 2'b00,0,0,0,0,0,0);                    // bubble
    for (int i = 0; i < 5; i++) begin
      apply32(s[i], we[i], wa[i], wd[i], v[i], 0, 1, $sformatf("link_r0_flush[%0d]", i));
      got = sample32(); x = sb.pop_front(); n_vec++;
      if (got !== x.e) begin n_err++; $display("FAIL %s: got %s required %s", x.name, fmt(got), fmt(x.e)); end
    end
  endtask

  task automatic test_stall();
    obs_t got; sb_t x;
    in_t  s  [5];
    logic we [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic v  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0]  wa [5] = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd0};
    logic [63:0] wd [5] = '{64'h77, 64'h77, 64'h77, 64'h77, 64'h0};
    s[0] = mk(1,0,1,1,10,2'b00,0,0,64'h77,0,0,0);
    s[1] = mk(0,0,1,1,11,2'b00,0,0,64'h99,0,0,0);
    s[2] = mk(0,1,1,1,12,2'b00,0,0,64'h98,0,0,0);   // flush while held
    s[3] = mk(0,0,0,0,13,2'b00,0,0,64'h97,0,0,0);
    s[4] = mk(1,0,0,0,0, 2'b00,0,0,0,0,0,0);
    for (int i = 0; i < 5; i++) begin
      apply32(s[i], we[i], wa[i], wd[i], v[i], 0, 1, $sformatf("stall[%0d]", i));
      got = sample32(); x = sb.pop_front(); n_vec++;
      if (got !== x.e) begin n_err++; $display("FAIL %s: got %s required %s", x.name, fmt(got), fmt(x.e)); end
    end
  endtask

  task automatic test_counter();
    obs_t got; sb_t x;
    // Retire then clear on the same edge as that retire, then 17 retires.
    for (int i = 0; i < 20; i++) begin
      if (i < 18)
        apply32(mk(1,0,1,1,1,2'b00,0,0,64'(i),0,0,(i == 1)), 1,1,64'(i),1,0,1,
                $sformatf("counter[%0d]", i));
      else
        apply32(mk(1,0,0,0,0,2'b00,0,0,0,0,0,0), 0,0,0,0,0,1, $sformatf("counter[%0d]", i));
      got = sample32(); x = sb.pop_front(); n_vec++;
      if (got !== x.e) begin n_err++; $display("FAIL %s: got %s required %s", x.name, fmt(got), fmt(x.e)); end
    end
  endtask

  task automatic test_wide64();
    obs_t got; sb_t x;
    in_t  s [6];
    obs_t e [6];
    s[0] = mk(1,0,1,1,2,2'b01,2'b11,1,64'h100,RD64,0,0);   // full, o=0
    e[0] = ob(1,2,RD64,1,0,0);
    s[1] = mk(1,0,1,1,3,2'b01,2'b10,1,64'h104,RD64,0,0);   // word signed, o=4
    e[1] = ob(1,3,64'hFFFF_FFFF_8000_0001,1,0,1);
    s[2] = mk(1,0,1,1,3,2'b01,2'b10,0,64'h104,RD64,0,0);   // word unsigned, o=4
    e[2] = ob(1,3,64'h0000_0000_8000_0001,1,0,2);
    s[3] = mk(1,0,1,1,4,2'b01,2'b11,0,64'h104,RD64,0,0);   // full, o=4 misaligned
    e[3] = ob(0,4,RD64,1,1,3);
    s[4] = mk(1,0,1,1,5,2'b01,2'b10,0,64'h102,RD64,0,0);   // word, o=2 misaligned
    e[4] = ob(0,5,64'h0000_0000_4567_8000,1,1,4);
    s[5] = mk(1,0,0,0,0,2'b00,0,0,0,0,0,0);                // bubble
    e[5] = ob(0,0,0,0,0,5);
    for (int i = 0; i < 6; i++) begin
      apply64(s[i], e[i], $sformatf("wide64[%0d]", i));
      got = sample64(); x = sb.pop_front(); n_vec++;
      if (got !== x.e) begin n_err++; $display("FAIL %s: got %s required %s", x.name, fmt(got), fmt(x.e)); end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_misalign();
    test_link_r0_flush();
    test_stall();
    test_counter();
    test_wide64();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Parametrised, registered MIPS writeback stage that holds the MEM/WB pipeline register. It selects among ALU result, aligned and extended load data, or the link address (PC+4). It drives the register-file write port with one cycle of latency. It also handles stall and flush, suppresses writes to r0, flags misaligned loads, and keeps a retired-instruction counter.

Parameters:
DATA_W, 32, datapath width; multiple of 32 (32 or 64)
REG_AW, 5, register-file address width
CNT_W, 32, retired-instruction counter width
OFF_W, log2(DATA_W/8), byte-offset width (derived, not overridable)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  pipeline advance; 0 = hold WB register
flush  input  1  kill incoming instruction
in_valid  input  1  MEM stage holds a real instruction
reg_write  input  1  instruction writes a register
waddr  input  REG_AW  destination register
wb_sel  input  2  00 ALU, 01 MEM, 10 LINK, 11 reserved
load_size  input  2  00 byte, 01 half, 10 word(32b), 11 full DATA_W
load_signed  input  1  sign-extend load (1) or zero-extend (0)
alu_result  input  DATA_W  ALU result; low OFF_W bits are the load byte offset
read_data_mem  input  DATA_W  raw memory read word, aligned with the other inputs
pc_adder  input  DATA_W  PC+4 link value
cnt_clr  input  1  synchronous clear of retire_cnt
rf_we  output  1  register-file write enable
rf_waddr  output  REG_AW  register-file write address
rf_wdata  output  DATA_W  register-file write data
wb_valid  output  1  WB register holds a valid instruction
misalign  output  1  current WB load is misaligned
retire_cnt  output  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst=1): valid_q=0, fresh_q=0, rf_we=0, rf_waddr=0, rf_wdata=0, wb_valid=0, misalign=0, retire_cnt=0. Reset takes effect immediately mid-operation; any in-flight entry is discarded.
- Capture: on a rising edge with en=1, the WB register loads:
  - valid_q = in_valid & ~flush
  - fresh_q = 1
  - address and write flag
  - the selected, extended data
  - the misalign flag
  - If in_valid=0 or flush=1, a bubble loads (valid_q=0).
- flush has priority over in_valid; flush while en=0 has no effect.
- Hold: with en=0 the register keeps its contents and fresh_q clears. Result: each entry writes and retires exactly once, in its first WB cycle.
- Latency: one cycle from input to rf_we/rf_wdata. All outputs are flop-driven; no combinational path from inputs to outputs.
- Data select, computed before the register:
  - ALU: alu_result
  - LINK: pc_adder
  - reserved (11): zero
  - MEM: extracted load (below)
- Load extraction is big-endian over lanes. With o = alu_result[OFF_W-1:0], byte lane k is read_data_mem[DATA_W-1-8k -: 8].
  - byte: lane o
  - half: 16 bits starting at lane o
  - word: 32 bits starting at lane o
  - full: the whole word
  - The result is sign- or zero-extended to DATA_W per load_signed. full ignores load_signed. word ignores load_signed when DATA_W=32.
- misalign (wb_sel=01 only):
  - half with o[0]≠0
  - word with o[1:0]≠0
  - full with o≠0
  - load_size=11 when DATA_W=32 is treated as word.
- rf_we = valid_q & fresh_q & reg_write_q & (rf_waddr≠0) & ~misalign.
- rf_waddr and rf_wdata are still presented when rf_we=0.
- wb_valid = valid_q.
- misalign is an output reported while valid_q=1; it is 0 for bubbles.
- retire_cnt:
  - +1 on each cycle with valid_q & fresh_q, regardless of reg_write or misalign. Stores and branches also count.
  - Wraps modulo 2^CNT_W.
  - cnt_clr=1 sets it to 0 on the next edge. If cnt_clr coincides with a retire, the clear wins (result 0).

Test Plan:
- Reset: assert rst mid-stream with valid data captured -> all outputs 0 immediately, before the next clock edge. Deassert, then send an ALU write r5=0x1234_5678 -> rf_we=1, rf_waddr=5, rf_wdata=0x12345678 exactly one cycle later; retire_cnt=1.
- Loads, DATA_W=32, read_data_mem=0x80F1_7F22:
  - lb, o=0, signed -> 0xFFFF_FF80
  - lbu, o=3 -> 0x0000_0022
  - lh, o=2, signed -> 0x0000_7F22
  - lh, o=0, signed -> 0xFFFF_80F1
  - lw, o=0 -> 0x80F17F22
- Misaligned load: lw with o=2 and reg_write=1 -> misalign=1, rf_we=0, wb_valid=1, retire_cnt increments. lh with o=1 -> same.
- Link, r0, and flush:
  - jal: wb_sel=10, pc_adder=0x0040_0008, waddr=31 -> rf_wdata=0x00400008, rf_we=1.
  - Write to r0 -> rf_we=0, counted.
  - flush=1 with in_valid=1 -> wb_valid=0, rf_we=0, no count.
- Stall: capture a write, then hold en=0 for 3 cycles -> rf_we high for the first cycle only; wb_valid stays 1; retire_cnt +1 total. flush during the hold -> no change.
- Counter and width:
  - CNT_W=4, 17 retires -> retire_cnt=1.
  - cnt_clr together with a retire -> 0.
  - DATA_W=64, full load at o=0 -> full 64-bit word; ld word at o=4 signed with lanes 4..7=0x8000_0001 -> 0xFFFF_FFFF_8000_0001.
